// File: rtl/photo_hit_detector_if.sv
// Hit event stream: one sensor index per valid/ready handshake.
//   hit_valid  producer -> consumer  hit_index holds an unconsumed hit
//   hit_ready  consumer -> producer  consumer accepts the hit this cycle
//   hit_index  producer -> consumer  sensor number of the hit
interface photo_hit_detector_if;
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_index;

  modport master (output hit_valid, output hit_index, input hit_ready);
  modport slave  (input hit_valid, input hit_index, output hit_ready);
endinterface

// File: rtl/photo_hit_detector.sv
// Photodiode hit conditioner: per-channel two-flop synchroniser, debounce and
// falling-edge detect; pending hits are arbitrated round-robin onto a single
// valid/ready stream carrying the sensor index. Hits that arrive on an already
// pending channel are counted in a saturating drop counter.
//
// Optional feature: define HIT_LOCKOUT_EN to build a per-channel re-arm timer
// that ignores new edges for LOCKOUT_CYCLES after each grant.
//
// Ports:
//   clock         system clock
//   reset_n       asynchronous active-low reset
//   photo_array   raw photodiode levels (high = idle, falling edge = hit)
//   hit_if        master side of the hit stream (hit_valid/hit_ready/hit_index)
//   sensor_level  debounced channel levels
//   drop_count    saturating count of hits lost on already-pending channels
module photo_hit_detector #(
  parameter int unsigned N_SENSORS       = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOCKOUT_CYCLES  = 500000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_SENSORS-1:0]      photo_array,
  photo_hit_detector_if.master      hit_if,
  output logic [N_SENSORS-1:0]      sensor_level,
  output logic [7:0]                drop_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SENSORS-1:0] sync_q1;
  logic [N_SENSORS-1:0] sync_q2;
  logic [N_SENSORS-1:0] level_d;
  logic [N_SENSORS-1:0] pending;
  logic [DB_W-1:0]      db_cnt [N_SENSORS];
  logic [3:0]           rr_ptr;

  logic [N_SENSORS-1:0] edge_strobe;
  logic [N_SENSORS-1:0] lk_active;
  logic [N_SENSORS-1:0] arrival;
  logic [N_SENSORS-1:0] grant_vec;
  logic [N_SENSORS-1:0] drop_vec;
  logic                 slot_free;
  logic                 grant_any;
  logic [3:0]           grant_idx;
  logic [3:0]           ptr_next;
  logic [4:0]           drop_n;
  logic [8:0]           drop_sum;

  // Two-flop synchroniser, idle-high reset so no hit is seen out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= photo_array;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sensor_level <= '1;
      level_d      <= '1;
      for (int i = 0; i < N_SENSORS; i++) db_cnt[i] <= '0;
    end else begin
      level_d <= sensor_level;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (sync_q2[i] != sensor_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            sensor_level[i] <= sync_q2[i];
            db_cnt[i]       <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // One-cycle strobe on a debounced 1->0 transition
  assign edge_strobe = level_d & ~sensor_level;

`ifdef HIT_LOCKOUT_EN
  localparam int unsigned LK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  logic [LK_W-1:0] lk_cnt [N_SENSORS];

  // Re-arm timer: loaded on grant, counts down to zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SENSORS; i++) lk_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (grant_vec[i]) lk_cnt[i] <= LK_W'(LOCKOUT_CYCLES);
        else if (lk_cnt[i] != '0) lk_cnt[i] <= lk_cnt[i] - LK_W'(1);
      end
    end
  end

  always_comb begin
    lk_active = '0;
    for (int i = 0; i < N_SENSORS; i++) lk_active[i] = (lk_cnt[i] != '0);
  end
`else
  logic lockout_unused;
  assign lockout_unused = ^32'(LOCKOUT_CYCLES);
  assign lk_active      = '0;
`endif

  assign arrival   = edge_strobe & ~lk_active;
  assign slot_free = !hit_if.hit_valid || hit_if.hit_ready;

  // Round-robin pick: first pending channel at or after rr_ptr, wrapping
  always_comb begin
    int unsigned ch;
    ch        = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (slot_free) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        ch = 32'(rr_ptr) + 32'(i);
        if (ch >= N_SENSORS) ch = ch - N_SENSORS;
        if (!grant_any && ((pending & (N_SENSORS'(1) << ch)) != '0)) begin
          grant_any = 1'b1;
          grant_idx = 4'(ch);
        end
      end
    end
    for (int i = 0; i < N_SENSORS; i++) grant_vec[i] = grant_any && (grant_idx == 4'(i));
  end

  assign ptr_next = (grant_idx == 4'(N_SENSORS - 1)) ? 4'd0 : grant_idx + 4'd1;

  // Drops: a new arrival on a channel that stays pending this cycle
  always_comb begin
    drop_vec = arrival & pending & ~grant_vec;
    drop_n   = '0;
    for (int i = 0; i < N_SENSORS; i++) drop_n = drop_n + 5'(drop_vec[i]);
    drop_sum = 9'(drop_count) + 9'(drop_n);
  end

  // Pending bits, output slot and drop counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending          <= '0;
      rr_ptr           <= '0;
      hit_if.hit_valid <= 1'b0;
      hit_if.hit_index <= '0;
      drop_count       <= '0;
    end else begin
      // A strobe coincident with a grant re-sets the bit as a fresh hit
      pending    <= (pending & ~grant_vec) | arrival;
      drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
      if (slot_free) begin
        if (grant_any) begin
          hit_if.hit_valid <= 1'b1;
          hit_if.hit_index <= grant_idx;
          rr_ptr           <= ptr_next;
        end else begin
          hit_if.hit_valid <= 1'b0;
        end
      end
    end
  end

endmodule
